v_mul_seq: RTL
==============

# v_mul_seq

Element-group sequencer for the vector multiply unit; the stage directly upstream of `v_mul`. It accepts one `vmul.vv` instruction (vl, sew, register indices), reads 32-bit source words from the vector register file, and drives `v_mul` one word per cycle. It tracks `v_mul`'s fixed pipeline latency and catches each 32-bit product in a credit-protected result FIFO. It then presents products to VRF writeback with a valid/ready handshake and byte enables.

## Interface
Parameters:
- `MUL_LAT`, 4: cycles from operands at `v_mul` inputs to `result` valid.
- `VL_W`, 7: width of `vl`.
- `REG_AW`, 5: vector register index width.
- `WIDX_W`, 4: word-index width; at most 2^WIDX_W words per register.
- `FIFO_DEPTH`, MUL_LAT+2: result FIFO entries.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `nrst`, in, 1: asynchronous, active-low reset.
- `start_valid`, in, 1; `start_ready`, out, 1: instruction handshake.
- `vl`, in, VL_W; `sew`, in, 3; `vs1`, `vs2`, `vd`, in, REG_AW: instruction fields, sampled on start handshake.
- `rd_en`, out, 1; `rd_addr1`, `rd_addr2`, out, REG_AW; `rd_widx`, out, WIDX_W: VRF read request.
- `rd_data1`, `rd_data2`, in, 32: VRF data, valid the cycle after `rd_en`.
- `mul_op_A`, `mul_op_B`, out, 32; `mul_sew`, out, 3; `mul_is_mul`, out, 1: drive `v_mul`.
- `mul_result`, in, 32: `v_mul` output.
- `wb_valid`, out, 1; `wb_ready`, in, 1; `wb_addr`, out, REG_AW; `wb_widx`, out, WIDX_W; `wb_data`, out, 32; `wb_be`, out, 4: writeback.
- `busy`, out, 1; `done`, out, 1: `done` is a one-cycle pulse at instruction completion.

## Operation
- States are IDLE, ISSUE and DRAIN. `start_ready` is 1 only in IDLE.
- IDLE, on start handshake:
  - Latch all fields.
  - Compute nwords = (vl·2^sew + 3) >> 2, clamped to 2^WIDX_W.
  - If sew > 3'b010 or nwords = 0: pulse `done` next cycle and stay in IDLE. No reads, no writebacks.
  - Otherwise go to ISSUE.
- ISSUE: assert `rd_en` in a cycle only if inflight + fifo_count < FIFO_DEPTH.
  - `rd_addr1`=vs1, `rd_addr2`=vs2, `rd_widx`=current word. The word counter increments per issue.
  - After issuing word nwords−1, go to DRAIN.
- The cycle after each `rd_en`, `mul_op_A`=`rd_data2` and `mul_op_B`=`rd_data1` (combinational pass-through).
- A valid shift register of length 1+MUL_LAT tracks in-flight words. When its tail is set, push `mul_result` and that word's index into the FIFO.
- `mul_sew` holds the latched sew; `mul_is_mul`=1 throughout ISSUE and DRAIN. Both are needed because `v_mul` applies sew/is_mul combinationally at its output. In IDLE, `mul_is_mul`=0 and the operands are 0.
- DRAIN: when inflight = 0, FIFO is empty and no handshake is pending, pulse `done` and go to IDLE.
- Writeback:
  - `wb_valid` = FIFO not empty; the FIFO pops on `wb_valid && wb_ready`.
  - `wb_addr`=vd; `wb_data`/`wb_widx` come from the FIFO head.
- Credit rule: no `v_mul` result is ever dropped, because `v_mul` cannot stall.
- `busy` = state ≠ IDLE.
- Reset (any time, including mid-instruction): FIFO flushed, shift register cleared, state IDLE. All outputs are 0 except `start_ready`=1.

## Timing
- Start accepted at cycle 0; first `rd_en` at cycle 1.
- Operands reach `v_mul` at cycle 2; product is captured at cycle 2+MUL_LAT.
- Earliest `wb_valid` is cycle 3+MUL_LAT.
- With `wb_ready` held at 1, throughput is one word per cycle.
- FIFO push and pop in the same cycle are both performed; occupancy is unchanged.
- `done` asserts the cycle after the final pop. A new start is accepted no earlier than the cycle after `done`.

## Configuration
- `V_MUL_SEQ_TAIL_BE_EN` defined:
  - Non-last words: `wb_be`=4'hF.
  - Last word: `wb_be` has the low b bits set, where b = (vl·2^sew) mod 4, or 4'hF when b=0.
- Not defined: `wb_be` is always 4'hF. Tail bytes carry whatever products `v_mul` returns.

## Test plan
- sew=0, vl=4, vs2 word0 = 0x0203FF05, vs1 word0 = 0x03040206 -> one writeback of 0x060CFE1E at widx 0, `wb_be`=4'hF, `done` pulse; first `wb_valid` at cycle 3+MUL_LAT.
- sew=1, vl=3, halves (vs2: 7, −2, 100; vs1: 3, 5, −1) -> widx0 = 0xFFF60015, widx1 = 0x0000FF9C. With the macro on, widx1 `wb_be`=4'b0011; with it off, 4'hF.
- sew=2, vl=16, `wb_ready`=0 for 30 cycles then 1 -> `rd_en` count stalls at FIFO_DEPTH; all 16 products arrive in order at widx 0..15.
- vl=0, and separately sew=3'b011 with vl=8 -> `done` at cycle 1; no `rd_en`, no `wb_valid`.
- Deassert `nrst` at cycle 5 of a vl=16, sew=2 op -> outputs at reset values immediately. A following vl=4 op completes with exactly 1 writeback and no stale entries.

Source files
------------

// File: rtl/v_mul_seq.sv
// v_mul_seq: streams vmul.vv words from the VRF into v_mul and collects each product MUL_LAT cycles later; first wb_valid comes 3+MUL_LAT cycles after start.
// wb_ready stalls only throttle VRF reads through a FIFO credit, because v_mul cannot stall; tail byte enables come from V_MUL_SEQ_TAIL_BE_EN.
module v_mul_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (push) r_wp <= f_inc(r_wp);
      if (pop)  r_rp <= f_inc(r_rp);
      r_cnt <= r_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wp] <= push_dat;
  end

  assign head_dat = r_mem[r_rp];
  assign count    = r_cnt;
endmodule

module v_mul_seq #(
  parameter int MUL_LAT    = 4,
  parameter int VL_W       = 7,
  parameter int REG_AW     = 5,
  parameter int WIDX_W     = 4,
  parameter int FIFO_DEPTH = MUL_LAT + 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [VL_W-1:0]   vl,
  input  logic [2:0]        sew,
  input  logic [REG_AW-1:0] vs1,
  input  logic [REG_AW-1:0] vs2,
  input  logic [REG_AW-1:0] vd,
  output logic              rd_en,
  output logic [REG_AW-1:0] rd_addr1,
  output logic [REG_AW-1:0] rd_addr2,
  output logic [WIDX_W-1:0] rd_widx,
  input  logic [31:0]       rd_data1,
  input  logic [31:0]       rd_data2,
  output logic [31:0]       mul_op_A,
  output logic [31:0]       mul_op_B,
  output logic [2:0]        mul_sew,
  output logic              mul_is_mul,
  input  logic [31:0]       mul_result,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [WIDX_W-1:0] wb_widx,
  output logic [31:0]       wb_data,
  output logic [3:0]        wb_be,
  output logic              busy,
  output logic              done
);
  localparam int BW = VL_W + 3;
  localparam int NW = WIDX_W + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 4 + WIDX_W + 32;
  localparam logic [BW-3:0] MAX_WORDS = (BW-2)'(2 ** WIDX_W);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;
  state_t r_state, w_state_nxt;

  logic [REG_AW-1:0] r_vs1, r_vs2, r_vd;
  logic [2:0]        r_sew;
  logic [NW-1:0]     r_nwords;
  logic [WIDX_W-1:0] r_widx;
  logic              r_rej_done;
  logic [MUL_LAT:0]  r_vld;
  logic [WIDX_W-1:0] r_pipe_idx [MUL_LAT+1];
  logic [3:0]        r_pipe_be  [MUL_LAT+1];
  logic [CW-1:0]     r_inflight;

  logic [BW-1:0]     w_bytes, w_bytes_rnd;
  logic [BW-3:0]     w_nwords_raw;
  logic              w_clamp, w_reject, w_start, w_issue_last;
  logic              w_pop, w_push, w_drain_done;
  logic [3:0]        w_issue_be;
  logic [CW:0]       w_used;
  logic [CW-1:0]     w_fifo_cnt;
  logic [EW-1:0]     w_head;

  assign w_bytes      = BW'(vl) << sew[1:0];
  assign w_bytes_rnd  = w_bytes + BW'(3);
  assign w_nwords_raw = w_bytes_rnd[BW-1:2];
  assign w_clamp      = w_nwords_raw > MAX_WORDS;
  assign w_reject     = (sew > 3'd2) || (w_nwords_raw == '0);
  assign start_ready  = (r_state == S_IDLE) && !r_rej_done;
  assign w_start      = start_valid && start_ready;

  // A word holds a FIFO slot from its read until it is popped; a same-cycle pop returns one slot.
  assign w_pop        = wb_valid && wb_ready;
  assign w_used       = (CW+1)'(r_inflight) + (CW+1)'(w_fifo_cnt) - (CW+1)'(w_pop);
  assign rd_en        = (r_state == S_ISSUE) && (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_issue_last = ({1'b0, r_widx} == r_nwords - NW'(1));

`ifdef V_MUL_SEQ_TAIL_BE_EN
  logic [3:0] r_tail_be;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tail_be <= '0;
    end else if (w_start) begin
      r_tail_be <= (w_clamp || (w_bytes[1:0] == 2'd0)) ? 4'hF : ((4'd1 << w_bytes[1:0]) - 4'd1);
    end
  end
  assign w_issue_be = w_issue_last ? r_tail_be : 4'hF;
`else
  assign w_issue_be = 4'hF;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= S_IDLE;
      r_vs1      <= '0;
      r_vs2      <= '0;
      r_vd       <= '0;
      r_sew      <= '0;
      r_nwords   <= '0;
      r_widx     <= '0;
      r_rej_done <= 1'b0;
      r_vld      <= '0;
      r_inflight <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rej_done <= w_start && w_reject;
      if (w_start) begin
        r_vs1    <= vs1;
        r_vs2    <= vs2;
        r_vd     <= vd;
        r_sew    <= sew;
        r_nwords <= w_clamp ? NW'(MAX_WORDS) : NW'(w_nwords_raw);
        r_widx   <= '0;
      end else if (rd_en) begin
        r_widx   <= r_widx + WIDX_W'(1);
      end
      r_vld      <= {r_vld[MUL_LAT-1:0], rd_en};
      r_inflight <= r_inflight + CW'(rd_en) - CW'(w_push);
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_idx[0] <= r_widx;
    r_pipe_be[0]  <= w_issue_be;
    for (int k = 1; k <= MUL_LAT; k++) begin
      r_pipe_idx[k] <= r_pipe_idx[k-1];
      r_pipe_be[k]  <= r_pipe_be[k-1];
    end
  end

  assign w_drain_done = (r_inflight == '0) && (w_fifo_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start && !w_reject)  w_state_nxt = S_ISSUE;
      S_ISSUE: if (rd_en && w_issue_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drain_done)          w_state_nxt = S_IDLE;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  assign w_push = r_vld[MUL_LAT];

  v_mul_seq_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .nrst     (nrst),
    .push     (w_push),
    .push_dat ({r_pipe_be[MUL_LAT], r_pipe_idx[MUL_LAT], mul_result}),
    .pop      (w_pop),
    .head_dat (w_head),
    .count    (w_fifo_cnt)
  );

  assign wb_valid   = (w_fifo_cnt != '0);
  assign wb_addr    = r_vd;
  assign wb_data    = wb_valid ? w_head[31:0] : '0;
  assign wb_widx    = wb_valid ? w_head[WIDX_W+31:32] : '0;
  assign wb_be      = wb_valid ? w_head[EW-1:EW-4] : '0;
  assign rd_addr1   = r_vs1;
  assign rd_addr2   = r_vs2;
  assign rd_widx    = r_widx;
  assign mul_op_A   = r_vld[0] ? rd_data2 : '0;
  assign mul_op_B   = r_vld[0] ? rd_data1 : '0;
  assign mul_sew    = r_sew;
  assign busy       = (r_state != S_IDLE);
  assign mul_is_mul = busy;
  assign done       = r_rej_done || ((r_state == S_DRAIN) && w_drain_done);
endmodule
